stream_parity_checker: RTL and testbench
========================================

Name: stream_parity_checker

Overview:
- Parametrised, clocked successor to the 4-bit two-operand parity checker in the ALSU.
- Accumulates per-channel parity over a frame of FRAME_LEN data beats on NUM_CH independent WIDTH-bit channels.
- Compares each channel's accumulated parity against a trailing check beat and reports the selected channel's parity, zero-extended to WIDTH, with a per-channel error vector.
- Sits beside the ALSU operand path, fed by the operand registers, with results consumed by the ALSU output mux under valid/ready.

Parameters:
- WIDTH, 4, bits per channel and width of out_parity.
- NUM_CH, 2, number of channels (>=2).
- FRAME_LEN, 4, data beats per frame (>=1).
- SEL_W, $clog2(NUM_CH), width of ch_sel (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame abort, active high.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the first accepted beat of a frame.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- ch_sel  in  SEL_W  channel reported on out_parity; sampled at the check-beat handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_parity  out  WIDTH  {WIDTH-1 zeros, parity of selected channel}.
- err_vec  out  NUM_CH  bit k = 1 on parity mismatch on channel k.
- frame_cnt  out  SEL-independent 8  completed frames, wraps at 255 -> 0.

Behaviour:
- Reset (rst_n low, async): state ACCUM; beat counter 0; acc[k] = 0; out_valid 0; out_parity 0; err_vec 0; frame_cnt 0; in_ready 1 from the first clock after deassertion.
- FSM has three states.
  - ACCUM: each accepted beat sets acc[k] ^= ^in_data[k]. The first beat of a frame (count 0) loads rather than XORs and latches odd_mode. After FRAME_LEN beats, go to CHECK.
  - CHECK: the next accepted beat is the check beat. Bit 0 of each channel slice is the expected parity. Compute p[k] = acc[k] ^ mode_q. Register err_vec[k] = p[k] ^ expected[k], out_parity = {0, p[ch_sel]}, out_valid = 1. Go to RESULT. frame_cnt increments.
  - RESULT: in_ready = 0. Hold all outputs stable until out_ready. On the handshake, out_valid drops, the counter and acc clear, and the FSM returns to ACCUM.
- in_ready = 1 in ACCUM and CHECK, 0 in RESULT. Combinational from state only, with no path from in_valid.
- Latency: check-beat handshake at cycle N gives out_valid high at N+1. With out_ready held high, the next frame's first beat can be accepted at N+2.
- Out-of-range ch_sel (NUM_CH not a power of 2): out_parity = 0; err_vec is unaffected.
- clear:
  - In ACCUM or CHECK, clear drops the partial frame (counter and acc to 0, state ACCUM). A beat presented in the same cycle is discarded.
  - In RESULT, clear is ignored; results are never lost.
  - clear has priority over in_valid.
- odd_mode changes mid-frame have no effect until the next frame.
- out_parity, err_vec and frame_cnt are registered outputs with no combinational input-to-output paths.
- Reset mid-frame or mid-RESULT restores all reset values immediately; the pending result is lost.

Decomposition:
- Shared package/header (alsu_defs): the state encodings ST_ACCUM/ST_CHECK/ST_RESULT and the FRAME_CNT_W = 8 constant.
- One natural sub-module: parity_reduce, a combinational NUM_CH x WIDTH XOR-reduction producing an NUM_CH-bit per-beat parity vector. Instantiated once.
- Output channel selection reuses the existing 4-bit 2:1 mux only when NUM_CH=2. Otherwise it uses an indexed select in the top.

Test Plan:
- WIDTH=4, NUM_CH=2, FRAME_LEN=2, even mode. Ch0 beats 0001, 0011; ch1 beats 0111, 0000. Check beat ch0=0001, ch1=0001, ch_sel=1. Required: out_valid next cycle, out_parity=0001, err_vec=00, frame_cnt=1.
- Same data with odd_mode=1 on beat 1 and the same check beat. Required: err_vec=11, out_parity=0000.
- Backpressure: out_ready=0 for 5 cycles after the result. Required: in_ready=0, outputs stable, and in_valid beats are not accepted. out_ready=1 gives out_valid=0 the next cycle and in_ready=1.
- clear asserted with the second data beat. Required: the frame restarts, and a following full 2-beat frame plus check gives the result for the new data only.
- rst_n pulsed low asynchronously mid-RESULT (between edges). Required: out_valid, err_vec and frame_cnt go to 0 before the next clock edge.
- 256 back-to-back frames. Required: frame_cnt wraps to 0 and the throughput is one result per FRAME_LEN+2 cycles.

Source files
------------

// File: rtl/stream_parity_checker_pkg.sv
// Shared definitions for the stream parity checker.
//   state_e   : frame FSM state encoding (accumulate, await check beat, hold result)
//   FrameCntW : width of the completed-frame counter
package stream_parity_checker_pkg;

  typedef enum logic [1:0] {
    StAccum  = 2'd0,
    StCheck  = 2'd1,
    StResult = 2'd2
  } state_e;

  localparam int unsigned FrameCntW = 8;

endpackage

// File: rtl/stream_parity_checker_parity_reduce.sv
// Per-beat parity reduction: XOR-reduces each WIDTH-bit channel slice of a beat.
//   data   : NUM_CH*WIDTH beat, channel k at [k*WIDTH +: WIDTH]
//   parity : bit k = ^data[k*WIDTH +: WIDTH]
module parity_reduce #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH*WIDTH-1:0] data,
  output logic [NUM_CH-1:0]       parity
);

  always_comb begin
    parity = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      parity[k] = ^data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/stream_parity_checker.sv
// Framed multi-channel parity checker.
// Accumulates per-channel parity over FRAME_LEN data beats, then compares it with the
// bit-0 expectations carried by a trailing check beat and holds the result until consumed.
//   clk, rst_n          : clock, async active-low reset
//   clear               : synchronous abort of a partial frame (ignored while holding a result)
//   odd_mode            : parity sense, latched on the first beat of a frame
//   in_valid/in_ready   : beat handshake; in_data carries NUM_CH slices of WIDTH bits
//   ch_sel              : channel reported on out_parity, sampled with the check beat
//   out_valid/out_ready : result handshake
//   out_parity          : zero-extended parity of the selected channel
//   err_vec             : per-channel mismatch flags
//   frame_cnt           : completed frames, wrapping
module stream_parity_checker
  import stream_parity_checker_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned SEL_W     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    odd_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        ch_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_parity,
  output logic [NUM_CH-1:0]       err_vec,
  output logic [FrameCntW-1:0]    frame_cnt
);

  localparam int unsigned CntW = $clog2(FRAME_LEN) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]     acc_q, acc_d;
  logic                  mode_q, mode_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_parity_q, out_parity_d;
  logic [NUM_CH-1:0]     err_q, err_d;
  logic [FrameCntW-1:0]  frame_cnt_q, frame_cnt_d;

  logic [NUM_CH-1:0]     beat_par;
  logic [NUM_CH-1:0]     chk_par;
  logic [NUM_CH-1:0]     exp_par;
  logic                  sel_par;

  parity_reduce #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) u_parity_reduce (
    .data   (in_data),
    .parity (beat_par)
  );

  // Final parity of each channel, in the sense latched at frame start.
  assign chk_par = acc_q ^ {NUM_CH{mode_q}};

  // Check beat carries the expected parity in bit 0 of each channel slice.
  always_comb begin
    exp_par = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_par[k] = in_data[k*WIDTH];
    end
  end

  if (NUM_CH == 2) begin : g_mux2
    assign sel_par = ch_sel[0] ? chk_par[1] : chk_par[0];
  end else begin : g_idx
    localparam logic [SEL_W:0] NumChL = (SEL_W + 1)'(NUM_CH);
    always_comb begin
      sel_par = 1'b0;
      if ({1'b0, ch_sel} < NumChL) begin
        sel_par = chk_par[ch_sel];
      end
    end
  end

  assign in_ready = (state_q != StResult);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    err_d        = err_q;
    frame_cnt_d  = frame_cnt_q;

    unique case (state_q)
      StAccum: begin
        if (clear) begin
          cnt_d = '0;
          acc_d = '0;
        end else if (in_valid) begin
          if (cnt_q == '0) begin
            acc_d  = beat_par;
            mode_d = odd_mode;
          end else begin
            acc_d = acc_q ^ beat_par;
          end
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCheck: begin
        if (clear) begin
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StAccum;
        end else if (in_valid) begin
          err_d           = chk_par ^ exp_par;
          out_parity_d    = '0;
          out_parity_d[0] = sel_par;
          out_valid_d     = 1'b1;
          frame_cnt_d     = frame_cnt_q + 1'b1;
          state_d         = StResult;
        end
      end
      StResult: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          acc_d       = '0;
          state_d     = StAccum;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAccum;
      cnt_q        <= '0;
      acc_q        <= '0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= '0;
      err_q        <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign err_vec    = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_stream_parity_checker.sv
// Self-checking bench for stream_parity_checker (WIDTH=4, NUM_CH=2, FRAME_LEN=2).
// Expected results are queued when a check beat is driven and compared when the
// result handshake completes.
module tb_stream_parity_checker;

  localparam int unsigned Width    = 4;
  localparam int unsigned NumCh    = 2;
  localparam int unsigned FrameLen = 2;

  typedef struct packed {
    logic [3:0] par;
    logic [1:0] err;
    logic [7:0] fcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       odd_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [0:0] ch_sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_parity;
  logic [1:0] err_vec;
  logic [7:0] frame_cnt;

  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pop_n = 0;
  int   mark_n = -1;
  int   first_cyc = 0;
  int   last_cyc = 0;
  exp_t sb[$];
  logic [7:0] exp_fcnt = '0;

  stream_parity_checker #(
    .WIDTH     (Width),
    .NUM_CH    (NumCh),
    .FRAME_LEN (FrameLen)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .odd_mode   (odd_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ch_sel     (ch_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .err_vec    (err_vec),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: compares on every completed result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_parity", 32'(out_parity), 32'(e.par));
        check("sb_err", 32'(err_vec), 32'(e.err));
        check("sb_fcnt", 32'(frame_cnt), 32'(e.fcnt));
      end
      if (pop_n == mark_n) first_cyc = cyc;
      last_cyc = cyc;
      pop_n++;
    end
  end

  // Independent reference: parity over both data beats, then the check-beat compare.
  function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] chk, input logic odd, input logic sel,
                                 input logic [7:0] fcnt);
    exp_t e;
    logic [1:0] p;
    for (int k = 0; k < 2; k++) begin
      p[k] = (^b0[k*4 +: 4]) ^ (^b1[k*4 +: 4]) ^ odd;
      e.err[k] = p[k] ^ chk[k*4];
    end
    e.par  = {3'b000, p[sel]};
    e.fcnt = fcnt;
    return e;
  endfunction

  // Present one beat and hold it until accepted (in_ready is a function of state only).
  task automatic send_beat(input logic [7:0] d, input logic odd, input logic sel);
    logic acc;
    int   budget;
    in_valid = 1'b1;
    in_data  = d;
    odd_mode = odd;
    ch_sel   = sel;
    budget   = 0;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) check("beat_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] chk,
                           input logic odd, input logic sel, input bit push, input bit hold,
                           output exp_t e);
    exp_fcnt = exp_fcnt + 8'd1;
    e = model(b0, b1, chk, odd, sel, exp_fcnt);
    send_beat(b0, odd, 1'b0);
    send_beat(b1, ~odd, 1'b0);   // mode change mid-frame must be ignored
    if (push) sb.push_back(e);
    send_beat(chk, $urandom_range(0, 1), sel);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t e;

    // Reset values
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_parity", 32'(out_parity), 32'd0);
    check("rst_err", 32'(err_vec), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // Even mode, spec example
    run_frame(8'h71, 8'h03, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, e);
    check("t1_latency", 32'(out_valid), 32'd1);
    check("t1_parity", 32'(out_parity), 32'h1);
    check("t1_err", 32'(err_vec), 32'h0);
    check("t1_fcnt", 32'(frame_cnt), 32'd1);
    drain();
    check("t1_done_valid", 32'(out_valid), 32'd0);

    // Odd mode, same data and check beat
    run_frame(8'h71, 8'h03, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, e);
    check("t2_parity", 32'(out_parity), 32'h0);
    check("t2_err", 32'(err_vec), 32'h3);
    check("t2_fcnt", 32'(frame_cnt), 32'd2);
    drain();

    // Backpressure: result held, beats refused
    out_ready = 1'b0;
    run_frame(8'h5a, 8'hc3, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, e);
    in_valid = 1'b1;
    in_data  = 8'hff;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_parity", 32'(out_parity), 32'(e.par));
      check("bp_err", 32'(err_vec), 32'(e.err));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    // Proves the refused 0xff beat did not enter the next frame
    run_frame(8'h12, 8'h34, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, e);
    drain();

    // clear with the second data beat restarts the frame
    send_beat(8'h01, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h10;
    clear    = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    run_frame(8'h37, 8'h81, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, e);
    drain();

    // Async reset mid-result
    out_ready = 1'b0;
    run_frame(8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, e);
    check("rr_pre_valid", 32'(out_valid), 32'd1);
    check("rr_pre_err", 32'(err_vec), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("rr_valid", 32'(out_valid), 32'd0);
    check("rr_err", 32'(err_vec), 32'd0);
    check("rr_fcnt", 32'(frame_cnt), 32'd0);
    #1 rst_n = 1'b1;
    exp_fcnt  = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rr_ready", 32'(in_ready), 32'd1);

    // 256 back-to-back frames: counter wrap and throughput
    mark_n = pop_n;
    for (int i = 0; i < 256; i++) begin
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1, 1'b1, e);
    end
    in_valid = 1'b0;
    drain();
    check("burst_count", 32'(pop_n - mark_n), 32'd256);
    check("burst_period", 32'(last_cyc - first_cyc), 32'(255 * (FrameLen + 2)));
    check("burst_wrap", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'd1, 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
